dct2d_seq: RTL and testbench



---
 rtl/dct2d_seq.sv | 162 ++++++++++++++++
 tb/tb_dct2d_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct2d_seq.sv
// Row-column 8x8 2-D DCT sequencer around a free-running 8-point 1-D DCT core.
// Pixels in raster order, coefficients out in column order via a 64-entry transpose buffer.
module dct2d_seq #(
  parameter int BITS        = 25,
  parameter int PIX_W       = 8,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [BITS-1:0]  out_coef,
  output logic [2:0]       out_u,
  output logic [2:0]       out_v,
  output logic             block_done,
  output logic             busy,
  output logic             err,
  output logic             core_rst,
  output logic [BITS-1:0]  core_in,
  input  logic [BITS-1:0]  core_out,
  input  logic             core_finish
);

  typedef enum logic [1:0] {IDLE, ROW, COL, DRAIN} state_t;

  localparam int HALF = 1 << (PIX_W - 1);

  state_t          r_state;
  logic [2:0]      r_p;
  logic [4:0]      r_fc;
  logic            r_tail;
  logic [BITS-1:0] r_buf [64];

  logic [PIX_W-1:0] w_mag;
  logic             w_sign;
  logic [BITS-1:0]  w_pix_sm;
  logic             w_start;
  logic             w_fin_bad;
  logic             w_frame_end;
  logic [2:0]       w_idx_hi;
  logic [2:0]       w_idx_lo;
  logic             w_wr;
  logic             w_cap;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_mag  = in_pixel;
    w_sign = 1'b0;
    if (LEVEL_SHIFT != 0) begin
      if (in_pixel[PIX_W-1]) begin
        w_mag = in_pixel - PIX_W'(HALF);
      end else begin
        w_mag  = PIX_W'(HALF) - in_pixel;
        w_sign = 1'b1;
      end
    end
  end

  assign w_pix_sm    = {w_sign, (BITS-1)'(w_mag)};
  assign in_ready    = (r_state == ROW) || ((r_state == IDLE) && (r_p == 3'd0) && !core_rst);
  assign busy        = (r_state != IDLE);
  assign w_start     = (r_state == IDLE) && in_ready && in_valid;
  assign w_fin_bad   = (r_state != IDLE) && (core_finish != (r_p == 3'd1));
  assign w_frame_end = (r_p == 3'd7);

  // Coefficient j of a frame shows up at phase j+1 of the next frame, so the
  // producing frame is fc-1 except for coefficient 7, which lands at phase 0 of fc-2.
  assign w_idx_hi = r_fc[2:0] - ((r_p == 3'd0) ? 3'd2 : 3'd1);
  assign w_idx_lo = r_p - 3'd1;

  assign w_wr  = ((r_state == ROW) || (r_state == COL)) &&
                 (((r_p != 3'd0) && (r_fc >= 5'd1) && (r_fc <= 5'd8)) ||
                  ((r_p == 3'd0) && (r_fc >= 5'd2) && (r_fc <= 5'd9)));
  assign w_cap = ((r_state == COL) && ((r_fc >= 5'd10) || ((r_fc == 5'd9) && (r_p != 3'd0)))) ||
                 (r_state == DRAIN) || r_tail;

  always_comb begin
    core_in = '0;
    case (r_state)
      IDLE:    if (w_start) core_in = w_pix_sm;
      ROW:     core_in = w_pix_sm;
      COL:     core_in = r_buf[{r_p, r_fc[2:0]}];
      default: core_in = '0;
    endcase
  end

  // NOTE: the transpose buffer is plain storage with no reset; every entry is
  // rewritten by the row pass before the column pass reads it.
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[{w_idx_hi, w_idx_lo}] <= core_out;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_p        <= 3'd0;
      r_fc       <= 5'd0;
      r_tail     <= 1'b0;
      core_rst   <= 1'b1;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_coef   <= '0;
      out_u      <= 3'd0;
      out_v      <= 3'd0;
      block_done <= 1'b0;
    end else begin
      core_rst   <= 1'b0;
      r_p        <= core_rst ? 3'd0 : r_p + 3'd1;
      out_valid  <= w_cap;
      block_done <= r_tail;
      r_tail     <= (r_state == DRAIN) && w_frame_end && !w_fin_bad;
      if (w_cap) begin
        out_coef <= core_out;
        out_u    <= w_idx_lo;
        out_v    <= w_idx_hi;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            err     <= 1'b0;
            r_fc    <= 5'd0;
            r_state <= ROW;
          end
        end
        ROW: begin
          if (!in_valid || w_fin_bad) begin
            err     <= 1'b1;
            r_state <= IDLE;
          end else if (w_frame_end) begin
            r_fc <= r_fc + 5'd1;
            if (r_fc == 5'd7) r_state <= COL;
          end
        end
        COL: begin
          if (w_fin_bad) begin
            err     <= 1'b1;
            r_state <= IDLE;
          end else if (w_frame_end) begin
            r_fc <= r_fc + 5'd1;
            if (r_fc == 5'd15) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_fin_bad) begin
            err     <= 1'b1;
            r_state <= IDLE;
          end else if (w_frame_end) begin
            r_fc    <= r_fc + 5'd1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct2d_seq.sv
// Bench for dct2d_seq: behavioural 1-D core stand-in plus a direct 2-D golden sum.
`timescale 1ns/1ps
module tb_dct2d_seq;
  localparam int BITS  = 25;
  localparam int PIX_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel = '0;
  logic             out_valid;
  logic [BITS-1:0]  out_coef;
  logic [2:0]       out_u;
  logic [2:0]       out_v;
  logic             block_done;
  logic             busy;
  logic             err;
  logic             core_rst;
  logic [BITS-1:0]  core_in;
  logic [BITS-1:0]  core_out;
  logic             core_finish;

  dct2d_seq #(.BITS(BITS), .PIX_W(PIX_W), .LEVEL_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_coef(out_coef), .out_u(out_u), .out_v(out_v),
    .block_done(block_done), .busy(busy), .err(err), .core_rst(core_rst),
    .core_in(core_in), .core_out(core_out), .core_finish(core_finish)
  );

  initial forever #5 clk = ~clk;

  int cm [8][8] = '{
    '{16, 16, 16, 16, 16, 16, 16, 16},
    '{16, 13,  9,  3, -3, -9,-13,-16},
    '{15,  6, -6,-15,-15, -6,  6, 15},
    '{13, -3,-16, -9,  9, 16,  3,-13},
    '{11,-11,-11, 11, 11,-11,-11, 11},
    '{ 9,-16,  3, 13,-13, -3, 16, -9},
    '{ 6,-15, 15, -6, -6, 15,-15,  6},
    '{ 3, -9, 13,-16, 16,-13,  9, -3}};

  function automatic int from_sm(logic [BITS-1:0] s);
    int m = int'(s[BITS-2:0]);
    return s[BITS-1] ? -m : m;
  endfunction

  function automatic logic [BITS-1:0] to_sm(int v);
    logic [BITS-2:0] m;
    m = (v < 0) ? (BITS-1)'(-v) : (BITS-1)'(v);
    return {(v < 0), m};
  endfunction

  // Core stand-in: frame samples at phases 0..7, coefficient j out at next frame
  // phase j+1, coefficient 7 at phase 0 of the frame after that.
  logic [2:0] cp = 3'd0;
  int samp [8];
  int res1 [8];
  int res2 [8];
  bit force_fin_low = 1'b0;

  function automatic int core_coef(int k, int last);
    int s = 0;
    for (int n = 0; n < 8; n++) s += cm[k][n] * ((n == 7) ? last : samp[n]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (core_rst) begin
      cp <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        res1[i] <= 0;
        res2[i] <= 0;
      end
    end else begin
      cp <= cp + 3'd1;
      samp[cp] <= from_sm(core_in);
      if (cp == 3'd7) begin
        for (int k = 0; k < 8; k++) begin
          res1[k] <= core_coef(k, from_sm(core_in));
          res2[k] <= res1[k];
        end
      end
    end
  end

  always_comb begin
    core_out = '0;
    if (!core_rst) begin
      if (cp == 3'd0) core_out = to_sm(res2[7]);
      else            core_out = to_sm(res1[cp - 3'd1]);
    end
  end

  assign core_finish = !core_rst && (cp == 3'd1) && !force_fin_low;

  typedef struct {
    logic [BITS-1:0] coef;
    logic [2:0]      u;
    logic [2:0]      v;
    logic            done;
    int              cyc;
  } rec_t;

  typedef struct {
    int              pix;
    logic [BITS-1:0] dc;
  } vec_t;

  rec_t out_q[$];
  rec_t exp_q[$];
  int   hs_q[$];
  int   blk [64];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) out_q.push_back('{coef: out_coef, u: out_u, v: out_v, done: block_done, cyc: cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // 2-D golden straight from the definition Y[u][v] = sum C[u][r] C[v][n] x[r][n].
  task automatic push_golden();
    for (int v = 0; v < 8; v++) begin
      for (int u = 0; u < 8; u++) begin
        int s = 0;
        for (int r = 0; r < 8; r++)
          for (int n = 0; n < 8; n++) s += cm[u][r] * cm[v][n] * (blk[r*8+n] - 128);
        exp_q.push_back('{coef: to_sm(s), u: 3'(u), v: 3'(v), done: (u == 7 && v == 7), cyc: 0});
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 255));
  endtask

  task automatic send_block(input int drop_at);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_pixel = 8'(blk[0]);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("handshake_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    hs_q.push_back(cyc);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) begin
        in_valid = (i != drop_at);
        in_pixel = 8'(blk[i]);
      end
      @(negedge clk);
      if (i == 0) begin
        check("err_cleared", err, 0);
        check("busy_on", busy, 1);
      end
      if (i == drop_at) begin
        in_valid = 1'b0;
        check("drop_err", err, 1);
        check("drop_busy", busy, 0);
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_outputs(input int n);
    int g = 0;
    int hs = 0;
    while (out_q.size() < n && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("out_count", out_q.size(), n);
    for (int i = 0; i < n && out_q.size() > 0 && exp_q.size() > 0; i++) begin
      rec_t o;
      rec_t e;
      o = out_q.pop_front();
      e = exp_q.pop_front();
      check("coef", o.coef, e.coef);
      check("uv", {o.u, o.v}, {e.u, e.v});
      check("done", o.done, e.done);
      if (i % 64 == 0 && hs_q.size() > 0) begin
        hs = hs_q.pop_front();
        check("first_latency", o.cyc - hs, 74);
      end
      if (i % 64 == 63) check("done_latency", o.cyc - hs, 137);
    end
  endtask

  task automatic flush();
    out_q.delete();
    exp_q.delete();
    hs_q.delete();
  endtask

  initial begin
    vec_t tbl [4];
    int   g;
    int   ndone;
    tbl[0].pix = 128; tbl[0].dc = 25'h0000000;
    tbl[1].pix = 200; tbl[1].dc = 25'h0120000;
    tbl[2].pix = 0;   tbl[2].dc = 25'h1200000;
    tbl[3].pix = 255; tbl[3].dc = 25'h01FC000;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_coef", out_coef, 0);
    check("rst_out_uv", {out_u, out_v}, 0);
    check("rst_block_done", block_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_core_in", core_in, 0);
    check("rst_core_rst", core_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    check("core_rst_release", core_rst, 0);

    // Constant blocks: only the DC term survives.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) blk[i] = tbl[t].pix;
      for (int v = 0; v < 8; v++)
        for (int u = 0; u < 8; u++)
          exp_q.push_back('{coef: (u == 0 && v == 0) ? tbl[t].dc : '0, u: 3'(u), v: 3'(v),
                            done: (u == 7 && v == 7), cyc: 0});
      send_block(-1);
      check_outputs(64);
    end

    // Two random blocks back to back.
    fill_random();
    push_golden();
    send_block(-1);
    fill_random();
    push_golden();
    send_block(-1);
    if (hs_q.size() == 2) check("block_period", hs_q[1] - hs_q[0], 136);
    else check("block_period_count", hs_q.size(), 2);
    check_outputs(128);
    repeat (20) @(negedge clk);
    check("no_extra_outputs", out_q.size(), 0);

    // in_valid dropped at pixel 20: block discarded, then recovery.
    fill_random();
    send_block(20);
    repeat (150) @(negedge clk);
    check("drop_no_output", out_q.size(), 0);
    check("drop_err_sticky", err, 1);
    flush();
    fill_random();
    push_golden();
    send_block(-1);
    check_outputs(64);

    // Asynchronous reset in frame 12, then a fresh block.
    fill_random();
    send_block(-1);
    repeat (35) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_coef", out_coef, 0);
    check("mid_rst_out_uv", {out_u, out_v}, 0);
    check("mid_rst_block_done", block_done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_core_in", core_in, 0);
    check("mid_rst_core_rst", core_rst, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("core_rst_held", core_rst, 1);
    @(negedge clk);
    check("core_rst_cleared", core_rst, 0);
    check("ready_at_p0", in_ready, 1);
    flush();
    fill_random();
    push_golden();
    send_block(-1);
    check_outputs(64);

    // core_finish missing in a phase-1 cycle during the column pass.
    fill_random();
    send_block(-1);
    g = 0;
    while (cp != 3'd0 && g < 16) begin
      @(negedge clk);
      g++;
    end
    force_fin_low = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force_fin_low = 1'b0;
    check("fin_err", err, 1);
    check("fin_busy", busy, 0);
    repeat (150) @(negedge clk);
    ndone = 0;
    foreach (out_q[i]) if (out_q[i].done) ndone++;
    check("fin_no_done", ndone, 0);
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
